// File: rtl/rr_mux_arbiter.sv
// Registered N:1 data mux with fixed-select or round-robin arbitration and a valid/ready output stage.
// Optional per-channel saturating grant counters are enabled by defining RR_MUX_ARBITER_STATS_EN.
module rr_mux_arbiter #(
  parameter int WIDTH     = 16,
  parameter int SEL_WIDTH = 2,
  localparam int CHANNELS = 1 << SEL_WIDTH
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic [WIDTH*CHANNELS-1:0] In,
  input  logic [CHANNELS-1:0]       Req,
  input  logic                      Mode,
  input  logic [SEL_WIDTH-1:0]      S,
  output logic [CHANNELS-1:0]       Grant,
  output logic [WIDTH-1:0]          Out,
  output logic [SEL_WIDTH-1:0]      OutSel,
  output logic                      OutValid,
`ifdef RR_MUX_ARBITER_STATS_EN
  input  logic [SEL_WIDTH-1:0]      StatSel,
  input  logic                      StatClr,
  output logic [15:0]               StatCount,
`endif
  input  logic                      OutReady
);

  logic [WIDTH-1:0]     out_q, out_d;
  logic [SEL_WIDTH-1:0] out_sel_q, out_sel_d;
  logic                 out_valid_q, out_valid_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;

  logic [CHANNELS-1:0]  elig_s;
  logic [SEL_WIDTH-1:0] pick_idx_s;
  logic [SEL_WIDTH-1:0] cand_s;
  logic                 found_s;
  logic                 load_s;

  assign load_s = !out_valid_q || OutReady;

  // Eligible set and round-robin search starting one past the last granted channel.
  always_comb begin
    if (Mode) begin
      elig_s = Req;
    end else begin
      elig_s = Req & ({{(CHANNELS-1){1'b0}}, 1'b1} << S);
    end
    found_s    = 1'b0;
    pick_idx_s = {SEL_WIDTH{1'b0}};
    cand_s     = {SEL_WIDTH{1'b0}};
    for (int i = 1; i <= CHANNELS; i++) begin
      cand_s = ptr_q + SEL_WIDTH'(i);
      if (!found_s && elig_s[cand_s]) begin
        found_s    = 1'b1;
        pick_idx_s = cand_s;
      end else begin
        pick_idx_s = pick_idx_s;
      end
    end
  end

  // Grant is suppressed during reset so nothing is accepted while state is clearing.
  always_comb begin
    if (load_s && found_s && !Reset) begin
      Grant = {{(CHANNELS-1){1'b0}}, 1'b1} << pick_idx_s;
    end else begin
      Grant = {CHANNELS{1'b0}};
    end
  end

  // Output stage next state: refill on grant, empty on idle load, hold on stall.
  always_comb begin
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_s) begin
      if (found_s) begin
        out_d       = In[pick_idx_s*WIDTH +: WIDTH];
        out_sel_d   = pick_idx_s;
        out_valid_d = 1'b1;
        ptr_d       = pick_idx_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output and pointer registers; pointer resets to the last channel so channel 0 wins first.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      out_q       <= {WIDTH{1'b0}};
      out_sel_q   <= {SEL_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_WIDTH'(CHANNELS - 1);
    end else begin
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign Out      = out_q;
  assign OutSel   = out_sel_q;
  assign OutValid = out_valid_q;

`ifdef RR_MUX_ARBITER_STATS_EN
  logic [15:0] stat_cnt_q [CHANNELS];

  // Saturating per-channel grant counters; clear takes priority over increment.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        stat_cnt_q[k] <= 16'h0000;
      end
    end else if (StatClr) begin
      for (int k = 0; k < CHANNELS; k++) begin
        stat_cnt_q[k] <= 16'h0000;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (Grant[k] && (stat_cnt_q[k] != 16'hFFFF)) begin
          stat_cnt_q[k] <= stat_cnt_q[k] + 16'h0001;
        end
      end
    end
  end

  assign StatCount = stat_cnt_q[StatSel];
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (4 channels, 16-bit data).
module tb_rr_mux_arbiter;

  logic        CLK;
  logic        Reset;
  logic [63:0] In;
  logic [3:0]  Req;
  logic        Mode;
  logic [1:0]  S;
  logic [3:0]  Grant;
  logic [15:0] Out;
  logic [1:0]  OutSel;
  logic        OutValid;
  logic        OutReady;
`ifdef RR_MUX_ARBITER_STATS_EN
  logic [1:0]  StatSel;
  logic        StatClr;
  logic [15:0] StatCount;
`endif

  int checks_cnt = 0;
  int errors_cnt = 0;

  rr_mux_arbiter #(.WIDTH(16), .SEL_WIDTH(2)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .In       (In),
    .Req      (Req),
    .Mode     (Mode),
    .S        (S),
    .Grant    (Grant),
    .Out      (Out),
    .OutSel   (OutSel),
    .OutValid (OutValid),
`ifdef RR_MUX_ARBITER_STATS_EN
    .StatSel  (StatSel),
    .StatClr  (StatClr),
    .StatCount(StatCount),
`endif
    .OutReady (OutReady)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_sel;
    In       = {16'd4, 16'd3, 16'd2, 16'd1};
    Req      = 4'b0100;
    Mode     = 1'b0;
    S        = 2'd2;
    OutReady = 1'b1;
    Reset    = 1'b1;
`ifdef RR_MUX_ARBITER_STATS_EN
    StatSel  = 2'd0;
    StatClr  = 1'b0;
`endif
    step();

    // Reset state
    check_value("rst_grant", 32'(Grant), 32'h0);
    check_value("rst_out", 32'(Out), 32'h0);
    check_value("rst_outsel", 32'(OutSel), 32'h0);
    check_value("rst_valid", 32'(OutValid), 32'h0);

    // Fixed select S=2
    Reset = 1'b0;
    #1;
    check_value("fix_grant", 32'(Grant), 32'h4);
    step();
    check_value("fix_out", 32'(Out), 32'd3);
    check_value("fix_outsel", 32'(OutSel), 32'd2);
    check_value("fix_valid", 32'(OutValid), 32'h1);

    // Mode 0 sweep S=0..3
    Req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      S = 2'(i);
      #1;
      check_value("sweep_grant", 32'(Grant), 32'h1 << i);
      step();
      check_value("sweep_out", 32'(Out), 32'(i + 1));
    end

    // Mode 0 with selected channel not requesting: empties, data holds
    S   = 2'd3;
    Req = 4'b0001;
    #1;
    check_value("noelig_grant", 32'(Grant), 32'h0);
    step();
    check_value("noelig_valid", 32'(OutValid), 32'h0);
    check_value("noelig_out_hold", 32'(Out), 32'd4);
    check_value("noelig_sel_hold", 32'(OutSel), 32'd3);

    // Round robin, all requesting
    pulse_reset();
    Mode = 1'b1;
    Req  = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      exp_sel = 2'(i % 4);
      #1;
      check_value("rr_grant", 32'(Grant), 32'h1 << exp_sel);
      check_value("rr_onehot", 32'($countones(Grant)), 32'd1);
      step();
      check_value("rr_outsel", 32'(OutSel), 32'(exp_sel));
      check_value("rr_out", 32'(Out), 32'(exp_sel) + 32'd1);
    end

    // Round robin with stall
    pulse_reset();
    Req = 4'b1010;
    #1;
    check_value("stall_first_grant", 32'(Grant), 32'h2);
    step();
    check_value("stall_first_out", 32'(Out), 32'd2);
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_value("stall_grant", 32'(Grant), 32'h0);
      step();
      check_value("stall_out", 32'(Out), 32'd2);
      check_value("stall_valid", 32'(OutValid), 32'h1);
    end
    OutReady = 1'b1;
    #1;
    check_value("resume_grant", 32'(Grant), 32'h8);
    step();
    check_value("resume_out", 32'(Out), 32'd4);
    check_value("resume_outsel", 32'(OutSel), 32'd3);
    step();
    check_value("resume2_outsel", 32'(OutSel), 32'd1);
    check_value("resume2_out", 32'(Out), 32'd2);

    // Asynchronous reset mid-stream with Ptr=2
    pulse_reset();
    Mode = 1'b0;
    S    = 2'd2;
    Req  = 4'b0100;
    step();
    check_value("mid_pre_valid", 32'(OutValid), 32'h1);
    Reset = 1'b1;
    #1;
    check_value("mid_out", 32'(Out), 32'h0);
    check_value("mid_valid", 32'(OutValid), 32'h0);
    check_value("mid_grant", 32'(Grant), 32'h0);
    Mode = 1'b1;
    Req  = 4'b1111;
    #1;
    Reset = 1'b0;
    #1;
    check_value("post_rst_grant", 32'(Grant), 32'h1);
    step();
    check_value("post_rst_outsel", 32'(OutSel), 32'd0);
    check_value("post_rst_out", 32'(Out), 32'd1);

`ifdef RR_MUX_ARBITER_STATS_EN
    // Saturating grant counter on channel 0
    pulse_reset();
    Mode    = 1'b1;
    Req     = 4'b0001;
    StatSel = 2'd0;
    for (int i = 0; i < 5; i++) step();
    check_value("stat_five", 32'(StatCount), 32'd5);
    for (int i = 0; i < 70000; i++) step();
    check_value("stat_sat", 32'(StatCount), 32'hFFFF);
    StatClr = 1'b1;
    step();
    StatClr = 1'b0;
    check_value("stat_clr", 32'(StatCount), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
